a2d_scan_ctrl: RTL and testbench

Parametrised A2D channel sequencer between the push-button and LED top level and the SPI `A2D_intf`. Advances through `NUM_CHNNL` channels, either one channel per push-button release or autonomously at a fixed interval. Issues `strt_cnv` and waits for `cnv_cmplt` with a timeout. Stores the latest result per channel in a readable buffer and drives an LED slice of the most recent result.

---
 rtl/a2d_pkg.sv | 9 +
 rtl/pb_release_det.sv | 23 ++
 rtl/a2d_scan_ctrl.sv | 114 +++++++++++
 tb/tb_a2d_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// a2d_pkg: state encoding and default parameters for the A2D scan sequencer
package a2d_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, STORE} scan_state_t;
  localparam int DEF_NUM_CHNNL = 8;
  localparam int DEF_RES_W     = 12;
  localparam int DEF_LED_W     = 8;
  localparam int DEF_SCAN_DIV  = 50000;
  localparam int DEF_TMO_CYC   = 4096;
endpackage

// File: rtl/pb_release_det.sv
// pb_release_det: synchronise a raw active-low push button and flag its release for one cycle
module pb_release_det (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rel
);
  logic r_ff1, r_ff2, r_ff3, r_rel;
  // two-flop synchroniser, edge flop and registered release pulse; the idle level is "released"
  always_ff @(posedge clk)
    if (rst) begin
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
      r_ff3 <= 1'b1;
      r_rel <= 1'b0;
    end else begin
      r_ff1 <= i_btn;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
      r_rel <= r_ff2 & ~r_ff3;
    end
  assign o_rel = r_rel;
endmodule

// File: rtl/a2d_scan_ctrl.sv
// a2d_scan_ctrl: manual/auto A2D channel sequencer with timeout, result buffer and LED slice
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int NUM_CHNNL = DEF_NUM_CHNNL,
  parameter int RES_W     = DEF_RES_W,
  parameter int LED_W     = DEF_LED_W,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int TMO_CYC   = DEF_TMO_CYC,
  localparam int CH_W     = $clog2(NUM_CHNNL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nxt_chnnl,
  input  logic                 auto_mode,
  input  logic                 clr_err,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  input  logic                 cnv_cmplt,
  input  logic [RES_W-1:0]     res,
  input  logic [CH_W-1:0]      rd_chnnl,
  output logic [RES_W-1:0]     rd_data,
  output logic [NUM_CHNNL-1:0] vld,
  output logic [LED_W-1:0]     LEDs,
  output logic                 busy,
  output logic                 err
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int TMO_W = $clog2(TMO_CYC);
  scan_state_t r_state, w_nxt;
  logic [CH_W-1:0] r_chnnl;
  logic [DIV_W-1:0] r_div;
  logic [TMO_W-1:0] r_tmo;
  logic [RES_W-1:0] r_buf [NUM_CHNNL];
  logic [NUM_CHNNL-1:0] r_vld;
  logic [LED_W-1:0] r_leds;
  logic [RES_W-1:0] r_rd;
  logic r_pend, r_err, w_rel, w_go, w_wr, w_tmo;

  pb_release_det u_rel (
    .clk   (clk),
    .rst   (rst),
    .i_btn (nxt_chnnl),
    .o_rel (w_rel)
  );

  // next state: advance request from IDLE, completion or timeout from WAIT
  always_comb begin
    w_go  = 1'b0;
    w_wr  = 1'b0;
    w_tmo = 1'b0;
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_go  = auto_mode ? (r_div == DIV_W'(SCAN_DIV - 1)) : (w_rel | r_pend);
        w_nxt = w_go ? START : IDLE;
      end
      START: w_nxt = WAIT;
      WAIT: begin
        w_wr  = cnv_cmplt;
        w_tmo = ~cnv_cmplt & (r_tmo == TMO_W'(TMO_CYC - 1));
        w_nxt = w_wr ? STORE : (w_tmo ? IDLE : WAIT);
      end
      default: w_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_nxt;

  // channel pointer, one-deep pending request, interval/timeout counters and sticky error
  always_ff @(posedge clk)
    if (rst) begin
      r_chnnl <= CH_W'(NUM_CHNNL - 1);
      r_pend  <= 1'b0;
      r_div   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_go) r_chnnl <= (r_chnnl == CH_W'(NUM_CHNNL - 1)) ? '0 : r_chnnl + 1'b1;
      r_pend <= ~auto_mode & ~w_go & (r_pend | (w_rel & (r_state != IDLE)));
      r_div  <= (r_state == IDLE && auto_mode && !w_go) ? r_div + 1'b1 : '0;
      r_tmo  <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
      r_err  <= w_tmo | (r_err & ~clr_err);
    end

  // result buffer, valid bits and LED slice; a timeout invalidates the channel but keeps its data
  always_ff @(posedge clk)
    if (rst) begin
      r_buf  <= '{default: '0};
      r_vld  <= '0;
      r_leds <= '0;
    end else if (w_wr) begin
      r_buf[r_chnnl] <= res;
      r_vld[r_chnnl] <= 1'b1;
      r_leds         <= res[RES_W-1 -: LED_W];
    end else if (w_tmo) begin
      r_vld[r_chnnl] <= 1'b0;
    end

  // registered read port, write-first so a store in the same cycle is returned
  always_ff @(posedge clk)
    if (rst) r_rd <= '0;
    else r_rd <= (w_wr && rd_chnnl == r_chnnl) ? res : r_buf[rd_chnnl];

  assign strt_cnv = r_state == START;
  assign busy     = r_state == START || r_state == WAIT;
  assign chnnl    = 3'(r_chnnl);
  assign rd_data  = r_rd;
  assign vld      = r_vld;
  assign LEDs     = r_leds;
  assign err      = r_err;
endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// tb_a2d_scan_ctrl: self-checking bench for the A2D scan sequencer
module tb_a2d_scan_ctrl;
  localparam int N = 8, RW = 12, LW = 8, SD = 4;
  typedef struct {
    logic [RW-1:0] r;
    int            lat;
    logic [2:0]    ch;
    logic [LW-1:0] led;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, nxt_chnnl = 1'b1, auto_mode = 1'b0, clr_err = 1'b0, cnv_cmplt = 1'b0;
  logic [RW-1:0] res = '0;
  logic [2:0] rd_chnnl = '0;
  logic strt_cnv, busy, err;
  logic [2:0] chnnl;
  logic [RW-1:0] rd_data;
  logic [N-1:0] vld;
  logic [LW-1:0] leds;
  logic nxt3 = 1'b1, auto3 = 1'b0, c3 = 1'b0;
  logic [1:0] rd3 = '0;
  logic strt3, busy3, err3;
  logic [2:0] chnnl3;
  logic [RW-1:0] rd_data3;
  logic [2:0] vld3;
  logic [LW-1:0] leds3;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [RW-1:0] m_buf [N];
  logic [N-1:0] m_vld;
  logic [LW-1:0] m_led;
  int m_ch;
  vec_t vt [9];

  a2d_scan_ctrl #(.NUM_CHNNL(N), .RES_W(RW), .LED_W(LW), .SCAN_DIV(SD), .TMO_CYC(64)) u_dut (
    .clk(clk), .rst(rst), .nxt_chnnl(nxt_chnnl), .auto_mode(auto_mode), .clr_err(clr_err),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res), .rd_chnnl(rd_chnnl),
    .rd_data(rd_data), .vld(vld), .LEDs(leds), .busy(busy), .err(err)
  );

  a2d_scan_ctrl #(.NUM_CHNNL(3), .RES_W(RW), .LED_W(LW), .SCAN_DIV(SD), .TMO_CYC(16)) u_dut3 (
    .clk(clk), .rst(rst), .nxt_chnnl(nxt3), .auto_mode(auto3), .clr_err(clr_err),
    .strt_cnv(strt3), .chnnl(chnnl3), .cnv_cmplt(c3), .res(res), .rd_chnnl(rd3),
    .rd_data(rd_data3), .vld(vld3), .LEDs(leds3), .busy(busy3), .err(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic release_btn(input bit u3);
    if (u3) nxt3 = 1'b0; else nxt_chnnl = 1'b0;
    repeat (3) tick();
    if (u3) nxt3 = 1'b1; else nxt_chnnl = 1'b1;
  endtask

  task automatic wait_strt(input bit u3, input int lim, output int n);
    n = 0;
    while (!(u3 ? strt3 : strt_cnv) && n < lim) begin
      tick();
      n++;
    end
    n_chk++;
    if (!(u3 ? strt3 : strt_cnv)) begin
      n_fail++;
      $display("FAIL strt_wait: no strt_cnv within %0d cycles (u3=%0d)", lim, u3);
    end
  endtask

  task automatic press_start();
    int n;
    release_btn(1'b0);
    wait_strt(1'b0, 20, n);
    chk("rel_lat", n, 4);
  endtask

  // converts the channel just started: checks channel, answers after lat WAIT cycles, checks the store
  task automatic conv(input int lat, input logic [RW-1:0] v, input logic [2:0] ch_exp, input logic [LW-1:0] led_exp);
    chk("chnnl", chnnl, ch_exp);
    chk("busy_start", busy, 1);
    m_ch = ch_exp;
    repeat (lat) tick();
    res = v;
    cnv_cmplt = 1'b1;
    rd_chnnl = ch_exp;
    tick();
    cnv_cmplt = 1'b0;
    m_buf[m_ch] = v;
    m_vld[m_ch] = 1'b1;
    m_led = led_exp;
    chk("leds", leds, m_led);
    chk("vld", vld, m_vld);
    chk("rd_write_first", rd_data, v);
    chk("busy_store", busy, 0);
    tick();
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int n, s, prev, a;
    logic [RW-1:0] v;
    logic [RW-1:0] a3 [3];
    for (int i = 0; i < 9; i++) vt[i] = '{RW'((i % 8) * 256), 1 + i % 4, 3'(i % 8), LW'((i % 8) * 16)};
    for (int i = 0; i < N; i++) m_buf[i] = '0;
    m_vld = '0;
    m_led = '0;
    m_ch = N - 1;
    repeat (3) tick();
    chk("rst_chnnl", chnnl, 7);
    chk("rst_strt", strt_cnv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_vld", vld, 0);
    chk("rst_leds", leds, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_chnnl3", chnnl3, 2);
    rst = 1'b0;

    // auto scan on 3 channels: START gap = SD IDLE + 1 START + 3 WAIT + 1 STORE
    auto3 = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_strt(1'b1, 40, n);
      s = cyc;
      chk("auto_ch", chnnl3, i % 3);
      if (i > 0) chk("auto_gap", s - prev, SD + 1 + 3 + 1);
      prev = s;
      if (i < 3) begin
        nxt3 = 1'b0;
        tick();
        tick();
        nxt3 = 1'b1;
        tick();
      end else repeat (3) tick();
      v = RW'($urandom);
      a3[i % 3] = v;
      res = v;
      c3 = 1'b1;
      tick();
      c3 = 1'b0;
      chk("auto_leds", leds3, v[RW-1 -: LW]);
      if (i == 3) auto3 = 1'b0;
    end
    n = 0;
    repeat (20) begin
      tick();
      if (strt3) n++;
    end
    chk("auto_btn_ignored", n, 0);
    chk("auto_vld", vld3, 3'b111);

    // timeout after 16 WAIT cycles, then clear
    release_btn(1'b1);
    wait_strt(1'b1, 20, n);
    chk("tmo_ch", chnnl3, 1);
    repeat (16) tick();
    chk("tmo_busy_last", busy3, 1);
    chk("tmo_err_early", err3, 0);
    tick();
    chk("tmo_err", err3, 1);
    chk("tmo_idle", busy3, 0);
    chk("tmo_vld", vld3, 3'b101);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", err3, 0);
    // timeout and clear in the same cycle: set wins
    release_btn(1'b1);
    wait_strt(1'b1, 20, n);
    chk("tmo2_ch", chnnl3, 2);
    repeat (16) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_set_wins", err3, 1);
    chk("tmo2_vld", vld3, 3'b001);
    rd3 = 2'd2;
    tick();
    chk("tmo_buf_kept", rd_data3, a3[2]);

    // manual stepping table: channels 0..7,0 with res = 0x100*ch
    for (int i = 0; i < 9; i++) begin
      press_start();
      conv(vt[i].lat, vt[i].r, vt[i].ch, vt[i].led);
    end
    chk("vld_all", vld, 8'hFF);

    // cnv_cmplt outside WAIT is ignored
    res = 12'hFFF;
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0;
    tick();
    chk("idle_cmplt_leds", leds, m_led);
    chk("idle_cmplt_vld", vld, m_vld);
    chk("idle_cmplt_busy", busy, 0);

    // three releases while busy give exactly one extra conversion
    press_start();
    chk("pend_ch", chnnl, (m_ch + 1) % N);
    m_ch = (m_ch + 1) % N;
    repeat (3) begin
      nxt_chnnl = 1'b0;
      tick();
      tick();
      nxt_chnnl = 1'b1;
      tick();
      tick();
    end
    repeat (20) tick();
    v = RW'($urandom);
    res = v;
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0;
    m_buf[m_ch] = v;
    m_led = v[RW-1 -: LW];
    chk("pend_store_leds", leds, m_led);
    tick();
    chk("pend_idle", strt_cnv, 0);
    tick();
    chk("pend_strt", strt_cnv, 1);
    v = RW'($urandom);
    conv(2, v, 3'((m_ch + 1) % N), v[RW-1 -: LW]);
    n = 0;
    repeat (30) begin
      tick();
      if (strt_cnv) n++;
    end
    chk("pend_once", n, 0);

    // random conversions and reads against the model
    for (int i = 0; i < 12; i++) begin
      v = RW'($urandom);
      press_start();
      conv($urandom_range(1, 8), v, 3'((m_ch + 1) % N), v[RW-1 -: LW]);
      repeat (2) begin
        a = $urandom_range(0, N - 1);
        rd_chnnl = 3'(a);
        tick();
        chk("rd_rand", rd_data, m_buf[a]);
      end
    end

    // reset during WAIT, then a late cnv_cmplt must not write
    press_start();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rstw_chnnl", chnnl, 7);
    chk("rstw_busy", busy, 0);
    chk("rstw_strt", strt_cnv, 0);
    chk("rstw_vld", vld, 0);
    chk("rstw_leds", leds, 0);
    chk("rstw_rd", rd_data, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_buf[i] = '0;
    m_vld = '0;
    m_led = '0;
    m_ch = N - 1;
    res = 12'hABC;
    cnv_cmplt = 1'b1;
    tick();
    cnv_cmplt = 1'b0;
    tick();
    chk("late_vld", vld, 0);
    chk("late_leds", leds, 0);
    v = RW'($urandom);
    press_start();
    conv(2, v, 3'd0, v[RW-1 -: LW]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
